pipe_hazard_ctrl: RTL

Central pipeline sequencer for the five-stage ARM core. It decides every cycle whether each pipeline register advances, holds or takes a bubble. It covers three cases: multi-cycle data-memory accesses, load-use and RAW hazards seen in ID, and taken branches resolved in EXE. It drives the freeze/flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers, including the `flush` input of the ID/EXE stage register, and keeps saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the five-stage ARM core.
// Every cycle it decides whether each stage register advances, holds or
// takes a bubble. It handles multi-cycle memory accesses, ID-stage data
// hazards and taken branches resolved in EXE. It also keeps saturating
// stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fwd_en_i,
    input  logic [3:0]       id_src1_i,
    input  logic [3:0]       id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_two_src_i,
    input  logic [3:0]       exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_r_en_i,
    input  logic             exe_b_i,
    input  logic [3:0]       mem_dest_i,
    input  logic             mem_wb_en_i,
    input  logic             mem_req_i,
    input  logic             clr_cnt_i,
    output logic             pc_freeze_o,
    output logic             if_id_freeze_o,
    output logic             id_exe_freeze_o,
    output logic             exe_mem_freeze_o,
    output logic             if_id_flush_o,
    output logic             id_exe_flush_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        MEM_RUN,
        MEM_WAIT,
        MEM_DONE
    } mem_state_e;

    // An access that completes in one cycle never needs the FSM to leave RUN.
    localparam bit         SINGLE_CYCLE = (MEM_LAT == 1);
    localparam bit         TWO_CYCLE    = (MEM_LAT == 2);
    localparam logic [3:0] WAIT_INIT    = (MEM_LAT >= 3) ? 4'(MEM_LAT - 3) : 4'd0;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mem_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic exe_match;
    logic mem_match;
    logic hazard;
    logic branch;

    // Memory FSM and wait counter registers; reset abandons any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MEM_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory FSM next state: RUN starts an access, WAIT counts down, DONE acknowledges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MEM_RUN: begin
                if (mem_req_i && !SINGLE_CYCLE) begin
                    if (TWO_CYCLE) begin
                        state_d = MEM_DONE;
                    end else begin
                        state_d = MEM_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = MEM_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MEM_DONE: begin
                state_d = MEM_RUN;
            end
            default: begin
                state_d = MEM_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Hazard/branch detection and the stage-register control outputs.
    always_comb begin
        mem_busy = ((state_q == MEM_RUN) && mem_req_i && !SINGLE_CYCLE)
                   || (state_q == MEM_WAIT);

        exe_match = (id_use_src1_i && (exe_dest_i == id_src1_i))
                    || (id_two_src_i && (exe_dest_i == id_src2_i));
        mem_match = (id_use_src1_i && (mem_dest_i == id_src1_i))
                    || (id_two_src_i && (mem_dest_i == id_src2_i));

        hazard = !mem_busy
                 && ((exe_wb_en_i && exe_match && (!fwd_en_i || exe_mem_r_en_i))
                     || (!fwd_en_i && mem_wb_en_i && mem_match));
        branch = !mem_busy && exe_b_i;

        pc_freeze_o      = mem_busy || (hazard && !branch);
        if_id_freeze_o   = mem_busy || (hazard && !branch);
        id_exe_freeze_o  = mem_busy;
        exe_mem_freeze_o = mem_busy;
        mem_wb_bubble_o  = mem_busy;
        if_id_flush_o    = branch;
        id_exe_flush_o   = branch || hazard;
        mem_ack_o        = ((state_q == MEM_RUN) && mem_req_i && SINGLE_CYCLE)
                           || (state_q == MEM_DONE);

        if (rst_i) begin
            pc_freeze_o      = 1'b0;
            if_id_freeze_o   = 1'b0;
            id_exe_freeze_o  = 1'b0;
            exe_mem_freeze_o = 1'b0;
            mem_wb_bubble_o  = 1'b0;
            mem_ack_o        = 1'b0;
            if_id_flush_o    = 1'b1;
            id_exe_flush_o   = 1'b1;
        end
    end

    // Counter next values: clear wins over increment, and both stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (pc_freeze_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (if_id_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
